// File: rtl/rv_imem_loader.sv
// Boot-time loader: parses a counted, checksummed byte stream into 32-bit LE words,
// writes them into instruction memory and releases core reset once the image verifies.
module rv_imem_loader #(
    parameter int unsigned AW = 10
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          s_valid_i,
    input  logic [7:0]    s_data_i,
    output logic          s_ready_o,
    input  logic          reload_i,
    output logic          imem_we_o,
    output logic [AW-1:0] imem_waddr_o,
    output logic [31:0]   imem_wdata_o,
    output logic          core_rstn_o,
    output logic          done_o,
    output logic          err_o
);

    typedef enum logic [2:0] {
        S_HDR_LO,
        S_HDR_HI,
        S_PAYLOAD,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    state_t        state_q;
    logic [15:0]   count_q;
    logic [AW-1:0] addr_q;
    logic [7:0]    sum_q;
    logic [1:0]    bcnt_q;
    logic [31:0]   word_q;
    logic          we_q;
    logic [AW-1:0] waddr_q;
    logic [31:0]   wdata_q;
    logic          core_rstn_q;
    logic          done_q;
    logic          err_q;

    logic          accept;
    logic [15:0]   count_d;
    logic [31:0]   word_d;
    logic [7:0]    sum_d;
    logic          last_word;
    logic          count_bad;

    assign s_ready_o = (state_q == S_HDR_LO) || (state_q == S_HDR_HI) ||
                       (state_q == S_PAYLOAD) || (state_q == S_CHECK);
    assign accept    = s_valid_i & s_ready_o;
    assign count_d   = {s_data_i, count_q[7:0]};
    assign word_d    = {s_data_i, word_q[31:8]};
    assign sum_d     = sum_q + s_data_i;
    // Compared wide so that N = 2**AW terminates even though addr_q wraps afterwards.
    assign last_word = (32'(addr_q) == (32'(count_q) - 32'd1));
    assign count_bad = (count_d == 16'd0) || (32'(count_d) > (32'd1 << AW));

    assign imem_we_o    = we_q;
    assign imem_waddr_o = waddr_q;
    assign imem_wdata_o = wdata_q;
    assign core_rstn_o  = core_rstn_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_HDR_LO;
            count_q     <= '0;
            addr_q      <= '0;
            sum_q       <= '0;
            bcnt_q      <= '0;
            word_q      <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            core_rstn_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                S_HDR_LO: begin
                    if (accept) begin
                        count_q[7:0] <= s_data_i;
                        state_q      <= S_HDR_HI;
                    end
                end
                S_HDR_HI: begin
                    if (accept) begin
                        count_q <= count_d;
                        if (count_bad) begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= S_PAYLOAD;
                            addr_q  <= '0;
                            sum_q   <= '0;
                            bcnt_q  <= '0;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (accept) begin
                        sum_q  <= sum_d;
                        word_q <= word_d;
                        bcnt_q <= bcnt_q + 2'd1;
                        if (bcnt_q == 2'd3) begin
                            we_q    <= 1'b1;
                            waddr_q <= addr_q;
                            wdata_q <= word_d;
                            addr_q  <= addr_q + AW'(1);
                            if (last_word) begin
                                state_q <= S_CHECK;
                            end
                        end
                    end
                end
                S_CHECK: begin
                    if (accept) begin
                        if (s_data_i == sum_q) begin
                            state_q     <= S_DONE;
                            done_q      <= 1'b1;
                            core_rstn_q <= 1'b1;
                        end else begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    if (reload_i) begin
                        state_q     <= S_HDR_LO;
                        done_q      <= 1'b0;
                        err_q       <= 1'b0;
                        core_rstn_q <= 1'b0;
                        sum_q       <= '0;
                        addr_q      <= '0;
                        bcnt_q      <= '0;
                    end
                end
                default: state_q <= S_HDR_LO;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_imem_loader.sv
// Bench for rv_imem_loader: byte-position reference model checked every cycle,
// plus literal checks on the documented example images.
module tb_rv_imem_loader;

    localparam int AW = 10;

    typedef logic [7:0] bq_t[$];

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          s_valid_i = 1'b0;
    logic [7:0]    s_data_i = 8'h00;
    logic          s_ready_o;
    logic          reload_i = 1'b0;
    logic          imem_we_o;
    logic [AW-1:0] imem_waddr_o;
    logic [31:0]   imem_wdata_o;
    logic          core_rstn_o;
    logic          done_o;
    logic          err_o;

    int n_cmp = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    logic [AW-1:0] log_a[$];
    logic [31:0]   log_d[$];

    rv_imem_loader #(.AW(AW)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .s_valid_i    (s_valid_i),
        .s_data_i     (s_data_i),
        .s_ready_o    (s_ready_o),
        .reload_i     (reload_i),
        .imem_we_o    (imem_we_o),
        .imem_waddr_o (imem_waddr_o),
        .imem_wdata_o (imem_wdata_o),
        .core_rstn_o  (core_rstn_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: tracks the byte position in the stream rather than any state machine.
    int            m_pos;
    logic [15:0]   m_n;
    logic [7:0]    m_lo;
    logic [7:0]    m_sum;
    logic [7:0]    m_wb[4];
    logic          m_done, m_err, m_we;
    logic [AW-1:0] m_waddr;
    logic [31:0]   m_wdata;
    logic          m_ready;

    assign m_ready = !(m_done || m_err);

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_pos   <= 0;
            m_n     <= '0;
            m_lo    <= '0;
            m_sum   <= '0;
            m_done  <= 1'b0;
            m_err   <= 1'b0;
            m_we    <= 1'b0;
            m_waddr <= '0;
            m_wdata <= '0;
        end else begin
            m_we <= 1'b0;
            if (!m_ready) begin
                if (reload_i) begin
                    m_pos  <= 0;
                    m_sum  <= '0;
                    m_done <= 1'b0;
                    m_err  <= 1'b0;
                end
            end else if (s_valid_i) begin
                if (m_pos == 0) begin
                    m_lo  <= s_data_i;
                    m_pos <= 1;
                end else if (m_pos == 1) begin
                    if (int'({s_data_i, m_lo}) == 0 || int'({s_data_i, m_lo}) > (1 << AW)) begin
                        m_err <= 1'b1;
                    end else begin
                        m_n   <= {s_data_i, m_lo};
                        m_pos <= 2;
                        m_sum <= '0;
                    end
                end else if (m_pos < 2 + 4 * int'(m_n)) begin
                    m_sum <= m_sum + s_data_i;
                    m_wb[(m_pos - 2) % 4] <= s_data_i;
                    m_pos <= m_pos + 1;
                    if ((m_pos - 2) % 4 == 3) begin
                        m_we    <= 1'b1;
                        m_waddr <= AW'((m_pos - 2) / 4);
                        m_wdata <= {s_data_i, m_wb[2], m_wb[1], m_wb[0]};
                    end
                end else begin
                    if (s_data_i == m_sum) m_done <= 1'b1;
                    else                   m_err  <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", 32'(s_ready_o), 32'(m_ready));
            chk("done", 32'(done_o), 32'(m_done));
            chk("err", 32'(err_o), 32'(m_err));
            chk("core_rstn", 32'(core_rstn_o), 32'(m_done));
            chk("we", 32'(imem_we_o), 32'(m_we));
            chk("waddr", 32'(imem_waddr_o), 32'(m_waddr));
            chk("wdata", imem_wdata_o, m_wdata);
            if (imem_we_o) begin
                log_a.push_back(imem_waddr_o);
                log_d.push_back(imem_wdata_o);
            end
        end
    end

    task automatic send(input logic [7:0] b, input int maxgap);
        int g;
        g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        repeat (g) begin
            s_valid_i = 1'b0;
            s_data_i  = 8'($urandom);
            @(negedge clk);
        end
        s_valid_i = 1'b1;
        s_data_i  = b;
        @(negedge clk);
        s_valid_i = 1'b0;
    endtask

    task automatic send_img(input bq_t q, input int maxgap);
        foreach (q[i]) send(q[i], maxgap);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reload();
        reload_i = 1'b1;
        @(negedge clk);
        reload_i = 1'b0;
    endtask

    function automatic bq_t mk_img(input int n, input bit good);
        bq_t q;
        logic [7:0] s;
        logic [7:0] b;
        s = 8'h00;
        q.push_back(8'(n));
        q.push_back(8'(n >> 8));
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            s = s + b;
            q.push_back(b);
        end
        q.push_back(good ? s : s + 8'h01);
        return q;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bq_t basic, bad, img2, q;
        int base;

        basic = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
        bad   = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hB7};
        img2  = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h38};

        #1 rstn = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        #1;
        chk("rst ready", 32'(s_ready_o), 32'd1);
        chk("rst we", 32'(imem_we_o), 32'd0);
        chk("rst done", 32'(done_o), 32'd0);
        chk("rst core_rstn", 32'(core_rstn_o), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Basic load
        base = log_a.size();
        send_img(basic, 0);
        settle();
        chk("basic nwr", 32'(log_a.size() - base), 32'd2);
        if (log_a.size() - base >= 2) begin
            chk("basic a0", 32'(log_a[base]), 32'd0);
            chk("basic d0", log_d[base], 32'h0000_0013);
            chk("basic a1", 32'(log_a[base + 1]), 32'd1);
            chk("basic d1", log_d[base + 1], 32'h0010_0093);
        end
        chk("basic done", 32'(done_o), 32'd1);
        chk("basic core_rstn", 32'(core_rstn_o), 32'd1);
        chk("basic err", 32'(err_o), 32'd0);
        chk("basic ready", 32'(s_ready_o), 32'd0);

        // Reload, then second image with a reload pulse ignored mid-payload
        @(negedge clk);
        do_reload();
        #1;
        chk("reload done", 32'(done_o), 32'd0);
        chk("reload core_rstn", 32'(core_rstn_o), 32'd0);
        chk("reload ready", 32'(s_ready_o), 32'd1);
        @(negedge clk);
        base = log_a.size();
        for (int i = 0; i < 4; i++) send(img2[i], 0);
        do_reload();
        for (int i = 4; i < img2.size(); i++) send(img2[i], 0);
        settle();
        chk("img2 nwr", 32'(log_a.size() - base), 32'd1);
        if (log_a.size() > base) begin
            chk("img2 a0", 32'(log_a[base]), 32'd0);
            chk("img2 d0", log_d[base], 32'hDEAD_BEEF);
        end
        chk("img2 done", 32'(done_o), 32'd1);

        // Bad checksum with handshake gaps
        @(negedge clk);
        do_reload();
        base = log_a.size();
        send_img(bad, 3);
        settle();
        chk("bad nwr", 32'(log_a.size() - base), 32'd2);
        chk("bad err", 32'(err_o), 32'd1);
        chk("bad core_rstn", 32'(core_rstn_o), 32'd0);
        chk("bad ready", 32'(s_ready_o), 32'd0);

        // Header bounds: zero count and 1025
        @(negedge clk);
        do_reload();
        base = log_a.size();
        send(8'h00, 0);
        send(8'h00, 0);
        settle();
        chk("cnt0 err", 32'(err_o), 32'd1);
        chk("cnt0 nwr", 32'(log_a.size() - base), 32'd0);
        @(negedge clk);
        do_reload();
        send(8'h01, 0);
        send(8'h04, 0);
        settle();
        chk("cnt1025 err", 32'(err_o), 32'd1);

        // Basic load with gaps must reproduce the same write sequence
        @(negedge clk);
        do_reload();
        base = log_a.size();
        send_img(basic, 4);
        settle();
        chk("gap nwr", 32'(log_a.size() - base), 32'd2);
        if (log_a.size() - base >= 2) begin
            chk("gap d0", log_d[base], 32'h0000_0013);
            chk("gap d1", log_d[base + 1], 32'h0010_0093);
        end

        // Random images, good and bad checksums
        for (int it = 0; it < 8; it++) begin
            @(negedge clk);
            do_reload();
            q = mk_img(int'($urandom_range(8, 1)), ($urandom_range(3, 0) != 0));
            send_img(q, 2);
            settle();
        end

        // Asynchronous reset mid-payload
        @(negedge clk);
        do_reload();
        for (int i = 0; i < 7; i++) send(basic[i], 0);
        #2 rstn = 1'b0;
        #1;
        chk("arst ready", 32'(s_ready_o), 32'd1);
        chk("arst we", 32'(imem_we_o), 32'd0);
        chk("arst waddr", 32'(imem_waddr_o), 32'd0);
        chk("arst wdata", imem_wdata_o, 32'd0);
        chk("arst done", 32'(done_o), 32'd0);
        chk("arst err", 32'(err_o), 32'd0);
        chk("arst core_rstn", 32'(core_rstn_o), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        base = log_a.size();
        send_img(basic, 1);
        settle();
        chk("post-rst nwr", 32'(log_a.size() - base), 32'd2);
        if (log_a.size() - base >= 2) begin
            chk("post-rst a0", 32'(log_a[base]), 32'd0);
            chk("post-rst d1", log_d[base + 1], 32'h0010_0093);
        end
        chk("post-rst done", 32'(done_o), 32'd1);

        // Maximum image: 1024 words
        @(negedge clk);
        do_reload();
        base = log_a.size();
        q = mk_img(1 << AW, 1'b1);
        send_img(q, 0);
        settle();
        chk("max nwr", 32'(log_a.size() - base), 32'd1024);
        if (log_a.size() > base) chk("max last addr", 32'(log_a[$]), 32'h3FF);
        chk("max done", 32'(done_o), 32'd1);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_imem_loader.md
# rv_imem_loader

Boot-time loader that writes a program image into the core's instruction memory. It receives a byte stream over a valid/ready handshake, assembles little-endian 32-bit words and drives the instruction-memory write port. It holds the core in reset until the whole image has been written and its checksum verified. It sits between the host/debug byte source and the instruction memory, and owns the core's reset release.

## Interface
- AW, 10, instruction-memory word-address width; maximum image = 2**AW words
- clk  in  1  system clock, all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- s_valid_i  in  1  byte-stream valid
- s_data_i  in  8  byte-stream data
- s_ready_o  out  1  loader accepts a byte this cycle; a byte transfers on a rising edge with s_valid_i & s_ready_o
- reload_i  in  1  re-arm request; honoured only in DONE or ERR
- imem_we_o  out  1  instruction-memory write strobe, one cycle per word
- imem_waddr_o  out  AW  word address of the write
- imem_wdata_o  out  32  write data
- core_rstn_o  out  1  active-low reset to the core; high only in DONE
- done_o  out  1  image loaded and checksum matched
- err_o  out  1  header or checksum error

## Operation
- Stream format: count low byte, count high byte (N words, 16-bit LE), then 4·N payload bytes, then 1 checksum byte. The checksum is the 8-bit wrapping sum of all payload bytes.
- Each word is little-endian: the first payload byte of a word goes to wdata[7:0], the fourth goes to [31:24].
- States: HDR_LO → HDR_HI → PAYLOAD → CHECK → DONE; any error → ERR. The reset state is HDR_LO.
- HDR_LO: accepting a byte latches count[7:0] and moves to HDR_HI.
- HDR_HI: accepting a byte latches count[15:8].
  - If the full count is 0 or greater than 2**AW → ERR.
  - Otherwise → PAYLOAD, with the word address and checksum cleared.
- PAYLOAD: each accepted byte is added to the running sum and shifted into the word assembler (new byte into [31:24], shift right). A 2-bit byte counter tracks position within the word.
  - When the 4th byte of a word is accepted, the write is issued, the byte counter wraps to 0, and the address increments after the write.
  - When the 4th byte of word N−1 is accepted → CHECK.
- CHECK: accepting the byte compares it with the running sum. Equal → DONE; unequal → ERR.
- DONE: done_o=1, core_rstn_o=1, s_ready_o=0.
- ERR: err_o=1, core_rstn_o=0, s_ready_o=0.
- reload_i in DONE or ERR → HDR_LO, clearing done_o, err_o, core_rstn_o, sum, address and byte counter. reload_i is ignored in all other states.
- s_ready_o is a combinational decode of state: 1 in HDR_LO, HDR_HI, PAYLOAD and CHECK.
- Memory contents are never cleared by the loader. Partial images written before an error or reset remain in memory.

## Timing
- Reset values:
  - State HDR_LO, s_ready_o=1.
  - imem_we_o=0, imem_waddr_o=0, imem_wdata_o=0.
  - core_rstn_o=0, done_o=0, err_o=0.
  - All counters and the checksum are 0.
- Write latency: imem_we_o, imem_waddr_o and imem_wdata_o are registered. The strobe is high for exactly the one cycle following the edge that accepted the word's 4th byte.
- imem_waddr_o and imem_wdata_o hold their last values between writes.
- The loader never stalls; s_valid_i gaps of any length are tolerated with no effect on state.
- The checksum byte can be accepted at the earliest one cycle after the last byte, so the last write always completes before DONE.
- core_rstn_o, done_o and err_o are registered:
  - core_rstn_o and done_o change on the edge that accepts the checksum byte.
  - err_o changes on the edge that accepts the offending byte.
  - All three clear on the edge that samples reload_i.
- rstn asserted mid-load forces every output to its reset value immediately (asynchronously). A new load then starts from the header.
- Address wrap: with N=2**AW the final write is at address 2**AW−1. The address counter then wraps to 0, which is harmless because the block is in CHECK.

## Test plan
- **Basic load:** stream 02 00 | 13 00 00 00 | 93 00 10 00 | B6.
  - Expect 2 writes: addr0=0x00000013, addr1=0x00100093.
  - Expect done_o=1 and core_rstn_o=1 after the B6 edge, err_o=0, s_ready_o=0.
- **Bad checksum:** same image with B7 as the checksum byte.
  - Expect both writes, then err_o=1, core_rstn_o=0, s_ready_o=0.
- **Header bounds:**
  - Count 00 00 → ERR on the 2nd byte, with no writes.
  - Count 01 04 (1025) → ERR.
  - Count 00 04 (1024) with a correct sum → 1024 writes, the last at addr 0x3FF, then DONE.
- **Handshake gaps:** basic load with random s_valid_i deasserts between bytes.
  - Expect identical write data/address sequence and exactly one imem_we_o pulse per word.
- **Reload:** after DONE, pulse reload_i.
  - Expect core_rstn_o=0 and done_o=0 on that edge, s_ready_o=1.
  - A second image (01 00 | EF BE AD DE | 38) writes addr0=0xDEADBEEF, then DONE.
  - Also check that reload_i pulsed during PAYLOAD is ignored.
- **Reset mid-payload:** assert rstn low after 5 payload bytes.
  - Expect outputs to reach reset values without waiting for a clock edge.
  - After release, a full basic load succeeds from address 0.
